// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline types: stage payload bundles, their widths,
//                and the skid-buffer occupancy state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // MEM/WB payload bundle (72 bits)
    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] alu_result;
    } memwb_t;

    // EX/MEM payload bundle (73 bits)
    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rd;
    } exmem_t;

    localparam int c_memwb_w = $bits(memwb_t);
    localparam int c_exmem_w = $bits(exmem_t);

    // Number of entries held by the skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pstate_t;

    // Occupancy count reported for each buffer state; 3 is unreachable
    function automatic logic [1:0] occ_of(input pstate_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf_if
//  Description : Upstream/downstream handshake bundle of one pipeline stage
//                buffer, including flush and the occupancy report.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_buf_if #(
    parameter int W = pipe_pkg::c_memwb_w
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    // View from the stage buffer itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );

    // View from the surrounding pipeline / hazard logic
    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Pipeline stage register with valid/ready handshake, flush
//                (bubble insertion) and an optional 2-entry skid buffer.
//                All state changes on the falling edge of clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int W           = 72,
    parameter int SKID        = 1,
    parameter int BUBBLE_ZERO = 1
) (
    input  wire              clk,
    input  wire              rst_n,
    pipe_stage_buf_if.slave  bus
);

    logic         w_valid;
    logic         w_in_ready;
    logic [W-1:0] w_data_raw;
    logic [1:0]   w_occ;
    logic         w_accept;
    logic         w_drain;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_drain  = w_valid && bus.out_ready;

    generate
        if (SKID == 0) begin : g_single
            logic         r_valid;
            logic [W-1:0] r_data;

            // Single entry: flush beats accept, accept beats a bare drain
            always_ff @(negedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (bus.flush) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_data  <= bus.in_data;
                    r_valid <= 1'b1;
                end else if (w_drain) begin
                    r_valid <= 1'b0;
                end
            end

            // Room exists if the held entry is leaving or there is none
            assign w_in_ready = bus.out_ready || !r_valid;
            assign w_valid    = r_valid;
            assign w_data_raw = r_data;
            assign w_occ      = {1'b0, r_valid};
        end else begin : g_skid
            pstate_t      r_state;
            logic [W-1:0] r_main;
            logic [W-1:0] r_skb;
            logic         r_in_ready;

            // Two-entry FIFO; in_ready is kept as its own flop and cleared
            // exactly when the overflow entry fills
            always_ff @(negedge clk) begin
                if (!rst_n) begin
                    r_state    <= EMPTY;
                    r_main     <= '0;
                    r_skb      <= '0;
                    r_in_ready <= 1'b1;
                end else if (bus.flush) begin
                    r_state    <= EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (w_accept) begin
                                r_main  <= bus.in_data;
                                r_state <= ONE;
                            end
                        end
                        ONE: begin
                            if (w_accept && w_drain) begin
                                r_main <= bus.in_data;
                            end else if (w_accept) begin
                                r_skb      <= bus.in_data;
                                r_state    <= TWO;
                                r_in_ready <= 1'b0;
                            end else if (w_drain) begin
                                r_state <= EMPTY;
                            end
                        end
                        TWO: begin
                            // Upstream is blocked here, so only a drain moves
                            if (w_drain) begin
                                r_main     <= r_skb;
                                r_state    <= ONE;
                                r_in_ready <= 1'b1;
                            end
                        end
                        default: begin
                            r_state    <= EMPTY;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end

            assign w_in_ready = r_in_ready;
            assign w_valid    = (r_state != EMPTY);
            assign w_data_raw = r_main;
            assign w_occ      = occ_of(r_state);
        end
    endgenerate

    // Bubbles present zero data so control fields read inactive downstream
    assign bus.out_data  = ((BUBBLE_ZERO != 0) && !w_valid) ? '0 : w_data_raw;
    assign bus.out_valid = w_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Self-checking bench for pipe_stage_buf, SKID=1 via a vector
//                table and SKID=0 via a hand-written sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int c_w = 72;

    logic clk;
    logic rst_n;

    pipe_stage_buf_if #(.W(c_w)) bus0 ();
    pipe_stage_buf_if #(.W(c_w)) bus1 ();

    pipe_stage_buf #(.W(c_w), .SKID(0), .BUBBLE_ZERO(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    pipe_stage_buf #(.W(c_w), .SKID(1), .BUBBLE_ZERO(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic           rst_n;
        logic           flush;
        logic           in_valid;
        logic [c_w-1:0] in_data;
        logic           out_ready;
        logic           exp_valid;
        logic [c_w-1:0] exp_data;
        logic [1:0]     exp_occ;
        logic           exp_in_ready;
    } vec_t;

    vec_t   vecs [20];
    int     n_checks = 0;
    int     n_fail   = 0;
    memwb_t mw;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [c_w-1:0] act, input logic [c_w-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [c_w-1:0] d, input logic ordy,
                                input logic ev, input logic [c_w-1:0] ed,
                                input logic [1:0] eo, input logic eir);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_occ = eo; v.exp_in_ready = eir;
        return v;
    endfunction

    // Drive SKID=0 inputs, take one falling edge, then sample
    task automatic step0(input logic f, input logic iv, input logic [c_w-1:0] d, input logic ordy);
        bus0.flush = f; bus0.in_valid = iv; bus0.in_data = d; bus0.out_ready = ordy;
        @(negedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic ev, input logic [c_w-1:0] ed, input logic [1:0] eo);
        chk({tag, ".valid"}, {71'b0, bus0.out_valid}, {71'b0, ev});
        chk({tag, ".data"},  bus0.out_data, ed);
        chk({tag, ".occ"},   {70'b0, bus0.occupancy}, {70'b0, eo});
    endtask

    initial begin
        logic [c_w-1:0] ones;
        ones = '1;
        mw = '{reg_write: 1'b1, result_src: 2'b01, read_data: 32'hDEADBEEF,
               rd: 5'd7, alu_result: 32'h12345678};

        rst_n = 1'b0;
        bus0.flush = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

        //                 rst  fl  iv  data        or   ev  exp_data    occ  ir
        vecs[0]  = mk(1'b0, 0, 1, ones,       0,   0, '0,         2'd0, 1);
        vecs[1]  = mk(1'b0, 0, 1, ones,       0,   0, '0,         2'd0, 1);
        vecs[2]  = mk(1'b1, 0, 1, 72'h01,     1,   1, 72'h01,     2'd1, 1);
        vecs[3]  = mk(1'b1, 0, 1, 72'h02,     1,   1, 72'h02,     2'd1, 1);
        vecs[4]  = mk(1'b1, 0, 1, 72'h03,     1,   1, 72'h03,     2'd1, 1);
        vecs[5]  = mk(1'b1, 0, 0, '0,         1,   0, '0,         2'd0, 1);
        vecs[6]  = mk(1'b1, 0, 1, 72'hA1,     0,   1, 72'hA1,     2'd1, 1);
        vecs[7]  = mk(1'b1, 0, 1, 72'hA2,     0,   1, 72'hA1,     2'd2, 0);
        vecs[8]  = mk(1'b1, 0, 1, 72'hA3,     0,   1, 72'hA1,     2'd2, 0);
        vecs[9]  = mk(1'b1, 0, 0, '0,         1,   1, 72'hA2,     2'd1, 1);
        vecs[10] = mk(1'b1, 0, 0, '0,         1,   0, '0,         2'd0, 1);
        vecs[11] = mk(1'b1, 0, 1, 72'hD1,     0,   1, 72'hD1,     2'd1, 1);
        vecs[12] = mk(1'b1, 0, 1, 72'hD2,     0,   1, 72'hD1,     2'd2, 0);
        vecs[13] = mk(1'b1, 1, 1, 72'hB0,     1,   0, '0,         2'd0, 1);
        vecs[14] = mk(1'b1, 0, 0, '0,         1,   0, '0,         2'd0, 1);
        vecs[15] = mk(1'b1, 0, 1, 72'hE1,     0,   1, 72'hE1,     2'd1, 1);
        vecs[16] = mk(1'b0, 0, 1, 72'hE2,     1,   0, '0,         2'd0, 1);
        vecs[17] = mk(1'b1, 0, 0, '0,         1,   0, '0,         2'd0, 1);
        vecs[18] = mk(1'b1, 0, 1, mw,         1,   1, mw,         2'd1, 1);
        vecs[19] = mk(1'b1, 0, 0, '0,         1,   0, '0,         2'd0, 1);

        // SKID=1 table
        for (int i = 0; i < 20; i++) begin
            rst_n          = vecs[i].rst_n;
            bus1.flush     = vecs[i].flush;
            bus1.in_valid  = vecs[i].in_valid;
            bus1.in_data   = vecs[i].in_data;
            bus1.out_ready = vecs[i].out_ready;
            @(negedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), {71'b0, bus1.out_valid}, {71'b0, vecs[i].exp_valid});
            chk($sformatf("v%0d.data", i),  bus1.out_data, vecs[i].exp_data);
            chk($sformatf("v%0d.occ", i),   {70'b0, bus1.occupancy}, {70'b0, vecs[i].exp_occ});
            chk($sformatf("v%0d.in_ready", i), {71'b0, bus1.in_ready}, {71'b0, vecs[i].exp_in_ready});
        end
        // The bubble after the MEM/WB payload must show RegWrite inactive
        mw = memwb_t'(bus1.out_data);
        chk("bubble.reg_write", {71'b0, mw.reg_write}, 72'h0);
        bus1.in_valid = 1'b0;

        // SKID=0 sequence
        rst_n = 1'b0;
        step0(0, 1, ones, 0);
        rst_n = 1'b1;
        chk0("s0.reset", 0, '0, 2'd0);
        chk("s0.reset.in_ready", {71'b0, bus0.in_ready}, 72'h1);

        step0(0, 1, 72'hC1, 0);
        chk0("s0.load", 1, 72'hC1, 2'd1);
        chk("s0.stall.in_ready", {71'b0, bus0.in_ready}, 72'h0);

        step0(0, 1, 72'hC2, 0);
        chk0("s0.hold", 1, 72'hC1, 2'd1);

        // Raising out_ready must open in_ready before any edge
        bus0.out_ready = 1'b1; bus0.in_valid = 1'b1; bus0.in_data = 72'hC3;
        #1;
        chk("s0.comb.in_ready", {71'b0, bus0.in_ready}, 72'h1);
        step0(0, 1, 72'hC3, 1);
        chk0("s0.replace", 1, 72'hC3, 2'd1);

        step0(0, 0, '0, 1);
        chk0("s0.drain", 0, '0, 2'd0);

        step0(0, 1, 72'hC5, 1);
        chk0("s0.load2", 1, 72'hC5, 2'd1);

        step0(1, 1, 72'hC6, 1);
        chk0("s0.flush", 0, '0, 2'd0);

        step0(0, 0, '0, 1);
        chk0("s0.after_flush", 0, '0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register with a valid/ready handshake, flush (bubble insertion) and an optional 2-entry skid buffer.
- Replaces the fixed per-stage latch registers: ID/EX, EX/MEM and MEM/WB each instantiate it with their own payload bundle.
- Adds back-pressure (stall), flush and a registered in_ready path, so that hazard logic can stall or kill a stage without custom code in each stage.

Parameters:
- W, 72: payload width in bits. Default is the MEM/WB bundle width.
- SKID, 1: 0 = single register with a combinational in_ready; 1 = 2-entry skid buffer with a registered in_ready.
- BUBBLE_ZERO, 1: 1 = out_data is forced to all-zero whenever out_valid=0.

Ports:
- clk, input, 1: stage clock. All state updates on the falling edge.
- rst_n, input, 1: synchronous active-low reset, sampled on the falling edge of clk.
- in_valid, input, 1: upstream has a payload.
- in_ready, output, 1: stage can accept a payload this cycle.
- in_data, input, W: upstream payload.
- flush, input, 1: kill all held entries and any incoming payload.
- out_valid, output, 1: stage presents a valid payload.
- out_ready, input, 1: downstream accepts the payload. Tie to 1 for a no-stall stage.
- out_data, output, W: payload to the next stage.
- occupancy, output, 2: number of valid entries held (0..2).

Behaviour:
- Transfers:
  - An accept happens on a falling edge where in_valid && in_ready.
  - A drain happens on a falling edge where out_valid && out_ready.
  - Latency from in_data to out_data is one edge when the stage is empty.
- Reset (rst_n=0 at a falling edge):
  - out_valid=0, occupancy=0, out_data=0.
  - Every internal entry is invalidated.
  - In SKID=1, in_ready=1 from the first edge after reset.
- Reset mid-operation discards all held entries; no drain is reported.
- Flush (rst_n=1, flush=1 at an edge):
  - All entries are invalidated; occupancy goes to 0.
  - A simultaneous accept is dropped.
  - Flush has priority over accept and drain. A concurrent out_ready has no effect.
- Bubble rule: with BUBBLE_ZERO=1, out_data is all-zero whenever out_valid=0. This guarantees that control fields such as RegWrite read 0 in a bubble.
- Payload integrity: out_data is stable while out_valid=1 && out_ready=0.

SKID=0 mode:
- One entry.
- in_ready = out_ready || !out_valid (combinational).
- Accept: entry <= in_data, valid <= 1.
- Drain without accept: valid <= 0.
- occupancy = {1'b0, valid}.

SKID=1 mode:
- Two entries: MAIN drives out_data; SKB holds an overflow payload.
- in_ready = !skb_valid, taken directly from a flop.
- States: EMPTY (0 entries), ONE (MAIN valid), TWO (MAIN and SKB valid).
- Transitions:
  - EMPTY + accept -> ONE (MAIN <= in_data).
  - ONE + accept + drain -> ONE (MAIN <= in_data).
  - ONE + accept, no drain -> TWO (SKB <= in_data).
  - ONE + drain, no accept -> EMPTY.
  - TWO + drain -> ONE (MAIN <= SKB). No accept is possible because in_ready=0.
  - TWO, no drain -> TWO (hold).
- Ordering: strictly FIFO; payloads are never reordered or duplicated.
- occupancy: EMPTY=0, ONE=1, TWO=2. The value 3 never occurs.

Decomposition:
- Shared package pipe_pkg holds:
  - the memwb_t packed struct {reg_write 1, result_src 2, read_data 32, rd 5, alu_result 32} = 72 bits;
  - a similar struct for EX/MEM;
  - localparams for the widths of these structs;
  - the enum pstate_t {EMPTY, ONE, TWO}.
- No sub-module is needed. SKID is selected with a generate block inside pipe_stage_buf.

Test Plan:
- Reset: rst_n=0 for 2 edges with in_valid=1, in_data=72'hFF..F -> out_valid=0, out_data=0, occupancy=0. In SKID=1, in_ready=1 after release.
- Stream: out_ready=1; send 0x01, 0x02, 0x03 on consecutive edges -> each appears on out_data one edge later, in order; occupancy stays 1.
- Stall (SKID=1): send 0xA1 then 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1 held. Raise out_ready -> 0xA1 drains, then 0xA2 drains, then EMPTY.
- Flush priority: with TWO held, flush=1 together with in_valid=1 (data 0xB0) and out_ready=1 -> next edge out_valid=0, out_data=0, occupancy=0, and 0xB0 never appears.
- SKID=0 back-pressure: out_valid=1, out_ready=0 -> in_ready=0 combinationally. Raise out_ready and in_valid with data 0xC3 together -> out_data=0xC3 after the edge.
- Bubble: a MEM/WB payload with reg_write=1 drains, then no input is sent -> out_valid=0 and the reg_write bit is 0.
